// File: rtl/xfer_sequencer.sv
// xfer_sequencer: Start/Done handshaked controller for the memory-to-memory
// transfer datapath. It loads memory A, then pairs A words into memory B.
// It keeps shadow copies of counterA/counterB so that an abort can walk
// both counters back to zero without a reset.
module xfer_sequencer #(
  parameter int unsigned A_DEPTH = 8,
  parameter int unsigned B_DEPTH = 4
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       InValid,
  input  logic       Hold,
  input  logic       Abort,
  output logic       WEA,
  output logic       IncA,
  output logic       WEB,
  output logic       IncB,
  output logic       Busy,
  output logic       Done,
  output logic       Aborted,
  output logic [2:0] ps,
  output logic [2:0] ns
);

  localparam int unsigned AW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int unsigned BW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(A_DEPTH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(B_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_EVEN = 3'd2,
    RD_ODD  = 3'd3,
    DONE    = 3'd4,
    REALIGN = 3'd5
  } state_t;

  state_t        state, state_nx;
  state_t        abort_to;
  logic [AW-1:0] ptra;
  logic [BW-1:0] ptrb;
  logic [AW-1:0] lcnt;

  assign ps   = state;
  assign ns   = state_nx;
  assign Busy = (state != IDLE);

  // An abort with both counters already at zero needs no re-alignment.
  assign abort_to = (ptra == '0 && ptrb == '0) ? IDLE : REALIGN;

  // Next-state decode and strobe generation; Abort and Reset override all.
  always_comb begin
    state_nx = state;
    WEA      = 1'b0;
    IncA     = 1'b0;
    WEB      = 1'b0;
    IncB     = 1'b0;
    Done     = 1'b0;
    Aborted  = 1'b0;
    if (Reset) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (Start) state_nx = LOAD;
        end
        LOAD: begin
          if (Abort) begin
            state_nx = abort_to;
            Aborted  = (abort_to == IDLE);
          end else if (InValid) begin
            WEA  = 1'b1;
            IncA = 1'b1;
            if (lcnt == A_LAST) state_nx = RD_EVEN;
          end
        end
        RD_EVEN: begin
          if (Abort) begin
            state_nx = abort_to;
            Aborted  = (abort_to == IDLE);
          end else if (!Hold) begin
            IncA     = 1'b1;
            state_nx = RD_ODD;
          end
        end
        RD_ODD: begin
          if (Abort) begin
            state_nx = abort_to;
            Aborted  = (abort_to == IDLE);
          end else begin
            WEB      = 1'b1;
            IncA     = 1'b1;
            IncB     = 1'b1;
            state_nx = (ptrb == B_LAST) ? DONE : RD_EVEN;
          end
        end
        DONE: begin
          Done     = 1'b1;
          state_nx = IDLE;
        end
        REALIGN: begin
          IncA = (ptra != '0);
          IncB = (ptrb != '0);
          // Next pointer is zero when it already is zero or is about to wrap.
          if ((ptra == '0 || ptra == A_LAST) && (ptrb == '0 || ptrb == B_LAST)) begin
            state_nx = IDLE;
            Aborted  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register, shadow address pointers and load counter.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= IDLE;
      ptra  <= '0;
      ptrb  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_nx;
      ptra  <= ptra + AW'(IncA);
      ptrb  <= ptrb + BW'(IncB);
      lcnt  <= (state_nx == LOAD) ? lcnt + AW'(WEA) : '0;
    end
  end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed bench for xfer_sequencer with the default 8/4 depths.
module tb_xfer_sequencer;

  logic       clock = 1'b0;
  logic       Reset, Start, InValid, Hold, Abort;
  logic       WEA, IncA, WEB, IncB, Busy, Done, Aborted;
  logic [2:0] ps, ns;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc, donecyc, abcyc, nwea, nweb, nab, overlap;
  logic [31:0] weamask, webmask, incamask, incbmask, anymask;
  logic [2:0]  pa;
  logic [1:0]  pb;

  xfer_sequencer #(.A_DEPTH(8), .B_DEPTH(4)) dut (
    .clock(clock), .Reset(Reset), .Start(Start), .InValid(InValid),
    .Hold(Hold), .Abort(Abort), .WEA(WEA), .IncA(IncA), .WEB(WEB),
    .IncB(IncB), .Busy(Busy), .Done(Done), .Aborted(Aborted),
    .ps(ps), .ns(ns)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; donecyc = -1; abcyc = -1; nwea = 0; nweb = 0; nab = 0; overlap = 0;
    weamask = '0; webmask = '0; incamask = '0; incbmask = '0; anymask = '0;
    pa = '0; pb = '0;
  endtask

  // Sample the current cycle's outputs, then advance one clock.
  task automatic tick();
    #1;
    if (WEA)  begin weamask  |= 32'd1 << cyc; nwea++; end
    if (WEB)  begin webmask  |= 32'd1 << cyc; nweb++; end
    if (IncA) incamask |= 32'd1 << cyc;
    if (IncB) incbmask |= 32'd1 << cyc;
    if (WEA || WEB || IncA || IncB) anymask |= 32'd1 << cyc;
    if (WEA && WEB) overlap++;
    pa = pa + 3'(IncA);
    pb = pb + 2'(IncB);
    if (Done && donecyc < 0) donecyc = cyc;
    if (Aborted) begin nab++; abcyc = cyc; end
    @(posedge clock); #1;
    cyc++;
  endtask

  // Full uninterrupted transfer; optionally raise Start during the DONE cycle.
  task automatic plain_run(input string tag, input bit dstart);
    clr();
    Start = 1'b1; InValid = 1'b1; Hold = 1'b0; Abort = 1'b0;
    tick();
    Start = 1'b0;
    while (cyc <= 17) begin
      Start = dstart && (cyc == 17);
      tick();
    end
    Start = 1'b0;
    #1;
    chk({tag, "_done_cyc"}, donecyc, 17);
    chk({tag, "_nwea"}, nwea, 8);
    chk({tag, "_nweb"}, nweb, 4);
    chk({tag, "_ps18"}, ps, 0);
    chk({tag, "_busy18"}, Busy, 0);
    chk({tag, "_ptra"}, pa, 0);
    chk({tag, "_ptrb"}, pb, 0);
    tick();
    chk({tag, "_ps19"}, ps, 0);
  endtask

  initial begin
    clr();
    // Reset overrides active inputs
    Reset = 1'b1; Start = 1'b1; InValid = 1'b1; Hold = 1'b1; Abort = 1'b1;
    @(posedge clock); #1;
    chk("rst_ps", ps, 0);
    chk("rst_ns", ns, 0);
    chk("rst_outs", {WEA, IncA, WEB, IncB, Busy, Done, Aborted}, 0);
    Reset = 1'b0; Start = 1'b0; InValid = 1'b0; Hold = 1'b0; Abort = 1'b0;
    #1;
    chk("idle_outs", {WEA, IncA, WEB, IncB, Busy, Done, Aborted, ps, ns}, 0);
    @(posedge clock); #1;

    // Plain transfer
    plain_run("t1", 1'b0);
    chk("t1_weamask", weamask, 32'h0000_01FE);
    chk("t1_webmask", webmask, 32'h0001_5400);
    chk("t1_overlap", overlap, 0);

    // InValid toggling during LOAD
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc <= 24) begin
      InValid = cyc[0];
      tick();
    end
    #1;
    chk("t2_done_cyc", donecyc, 24);
    chk("t2_weamask", weamask, 32'h0000_AAAA);
    chk("t2_webmask", webmask, 32'h00AA_0000);
    chk("t2_ps25", ps, 0);

    // Hold on second RD_EVEN for 3 cycles; Hold in RD_ODD ignored
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc <= 20) begin
      Hold = (cyc == 10 || cyc == 11 || cyc == 12 || cyc == 13 || cyc == 15);
      tick();
    end
    Hold = 1'b0;
    chk("t3_done_cyc", donecyc, 20);
    chk("t3_webmask", webmask, 32'h000A_8400);
    chk("t3_incamask", incamask, 32'h000F_C7FE);
    chk("t3_stall_quiet", anymask & 32'h0000_3800, 0);
    chk("t3_ptrb", pb, 0);

    // Abort in LOAD at cycle 5 (ptrA=4)
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc <= 4) tick();
    Abort = 1'b1;
    #1;
    chk("t4_abort_strobes", {WEA, IncA, WEB, IncB, Aborted}, 0);
    chk("t4_abort_ns", ns, 5);
    tick();
    Abort = 1'b0;
    while (cyc <= 9) tick();
    #1;
    chk("t4_ps10", ps, 0);
    chk("t4_abcyc", abcyc, 9);
    chk("t4_nab", nab, 1);
    chk("t4_incamask", incamask, 32'h0000_03DE);
    chk("t4_nwea", nwea, 4);
    chk("t4_ptra", pa, 0);
    plain_run("t4r", 1'b0);

    // Abort in RD_ODD of pair 1 (ptrA=3, ptrB=1)
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc <= 11) tick();
    Abort = 1'b1;
    #1;
    chk("t5_ps12", ps, 3);
    chk("t5_abort_strobes", {WEA, IncA, WEB, IncB}, 0);
    chk("t5_abort_ns", ns, 5);
    tick();
    Abort = 1'b0;
    while (cyc <= 17) tick();
    #1;
    chk("t5_ps18", ps, 0);
    chk("t5_abcyc", abcyc, 17);
    chk("t5_nab", nab, 1);
    chk("t5_incbmask", incbmask, 32'h0000_E400);
    chk("t5_ptra", pa, 0);
    chk("t5_ptrb", pb, 0);

    // Abort with both pointers zero goes straight to IDLE
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b1;
    #1;
    chk("t6_aborted", Aborted, 1);
    chk("t6_ns", ns, 0);
    chk("t6_wea", WEA, 0);
    tick();
    Abort = 1'b0;
    #1;
    chk("t6_ps", ps, 0);
    chk("t6_busy", Busy, 0);

    // Reset mid-RD_EVEN, then Start during DONE is not accepted
    clr();
    Start = 1'b1; InValid = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc <= 10) tick();
    Reset = 1'b1;
    #1;
    chk("t7_ps11", ps, 2);
    tick();
    Reset = 1'b0;
    #1;
    chk("t7_after_rst", {WEA, IncA, WEB, IncB, Busy, Done, Aborted, ps, ns}, 0);
    @(posedge clock); #1;
    plain_run("t7", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
